// File: rtl/mem_refill_ctrl_pkg.sv
// Shared refill-controller types: FSM encoding and cache-line geometry.
package mem_refill_ctrl_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int WORD_OFF_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DFILL = 2'd1,
    ST_IFILL = 2'd2,
    ST_DONE  = 2'd3
  } refill_state_e;

  function automatic int line_off_w(input int line_words);
    return $clog2(line_words) + WORD_OFF_W;
  endfunction

endpackage

// File: rtl/mem_refill_ctrl_addr_gen.sv
// Line base latch and word counter; next_addr is the word address to issue next.
// On load, next_addr bypasses to the aligned miss address so the request goes out on the same edge.
module refill_addr_gen
  import mem_refill_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int AW         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [AW-1:0]                 load_addr,
  input  logic                          adv,
  input  logic                          clr,
  output logic [$clog2(LINE_WORDS)-1:0] cnt,
  output logic                          last,
  output logic [AW-1:0]                 next_addr
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = line_off_w(LINE_WORDS);
  localparam logic [AW-1:0] OFF_MASK = {{(AW-OFF_W){1'b0}}, {OFF_W{1'b1}}};

  logic [AW-1:0]    base_q, base_d, load_base;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  assign load_base = load_addr & ~OFF_MASK;
  assign last      = (cnt_q == IDX_W'(LINE_WORDS - 1));
  assign cnt       = cnt_q;
  assign next_addr = load ? load_base
                          : base_q + {{(AW-OFF_W){1'b0}}, cnt_q, {WORD_OFF_W{1'b0}}};

  // The counter saturates on the last word; only load or the DONE clear returns it to zero.
  always_comb begin
    base_d = load ? load_base : base_q;
    cnt_d  = cnt_q;
    if (load || clr) begin
      cnt_d = '0;
    end else if (adv && !last) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_refill_ctrl.sv
// Cache-line refill controller: data misses take priority over instruction misses, one word read in flight.
// Zero-wait memory gives Done 2*LINE_WORDS+1 cycles after the miss is accepted; all outputs registered.
module mem_refill_ctrl
  import mem_refill_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int AW         = 32
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Imiss,
  input  logic [AW-1:0]                 IMissAddr,
  input  logic                          Dmiss,
  input  logic [AW-1:0]                 DMissAddr,
  output logic                          MemReq,
  output logic [AW-1:0]                 MemAddr,
  input  logic                          MemAck,
  input  logic [31:0]                   MemRData,
  output logic                          IRefillValid,
  output logic                          DRefillValid,
  output logic [31:0]                   RefillData,
  output logic [$clog2(LINE_WORDS)-1:0] RefillIdx,
  output logic                          IRefillDone,
  output logic                          DRefillDone,
  output logic                          Busy
);

  localparam int IDX_W = $clog2(LINE_WORDS);

  refill_state_e    state_q, state_d;
  logic             own_d_q, own_d_d;
  logic             blk_i_q, blk_i_d, blk_d_q, blk_d_d;
  logic             mem_req_q, mem_req_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic             i_vld_q, i_vld_d, d_vld_q, d_vld_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             i_done_q, i_done_d, d_done_q, d_done_d;
  logic             busy_q, busy_d;

  logic             fill, ack, dmiss_ok, imiss_ok, load, last;
  logic [IDX_W-1:0] cnt;
  logic [AW-1:0]    next_addr;

  assign fill     = (state_q == ST_DFILL) || (state_q == ST_IFILL);
  assign ack      = fill && mem_req_q && MemAck;
  // A port that just finished stays masked until its miss line has been seen low.
  assign dmiss_ok = Dmiss && !blk_d_q;
  assign imiss_ok = Imiss && !blk_i_q;
  assign load     = (state_q == ST_IDLE) && (dmiss_ok || imiss_ok);

  refill_addr_gen #(
    .LINE_WORDS (LINE_WORDS),
    .AW         (AW)
  ) u_addr_gen (
    .clk       (Clk),
    .rst_n     (Rst),
    .load      (load),
    .load_addr (dmiss_ok ? DMissAddr : IMissAddr),
    .adv       (ack),
    .clr       (state_q == ST_DONE),
    .cnt       (cnt),
    .last      (last),
    .next_addr (next_addr)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      own_d_q <= 1'b0;
      blk_i_q <= 1'b0;
      blk_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      blk_i_q <= blk_i_d;
      blk_d_q <= blk_d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dmiss_ok)      state_d = ST_DFILL;
        else if (imiss_ok) state_d = ST_IFILL;
      end
      ST_DFILL, ST_IFILL: begin
        if (ack && last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    own_d_d    = load ? dmiss_ok : own_d_q;
    blk_i_d    = (state_q == ST_DONE) ? (!own_d_q && Imiss) : (blk_i_q && Imiss);
    blk_d_d    = (state_q == ST_DONE) ? ( own_d_q && Dmiss) : (blk_d_q && Dmiss);
    // Request drops for exactly the ack cycle, then re-issues at the advanced address.
    mem_req_d  = load || (fill && !ack);
    mem_addr_d = (load || (fill && !mem_req_q)) ? next_addr : mem_addr_q;
    i_vld_d    = ack && !own_d_q;
    d_vld_d    = ack &&  own_d_q;
    rdata_d    = ack ? MemRData : rdata_q;
    idx_d      = ack ? cnt : idx_q;
    i_done_d   = (state_q == ST_DONE) && !own_d_q;
    d_done_d   = (state_q == ST_DONE) &&  own_d_q;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      i_vld_q    <= 1'b0;
      d_vld_q    <= 1'b0;
      rdata_q    <= '0;
      idx_q      <= '0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      i_vld_q    <= i_vld_d;
      d_vld_q    <= d_vld_d;
      rdata_q    <= rdata_d;
      idx_q      <= idx_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      busy_q     <= busy_d;
    end
  end

  assign MemReq       = mem_req_q;
  assign MemAddr      = mem_addr_q;
  assign IRefillValid = i_vld_q;
  assign DRefillValid = d_vld_q;
  assign RefillData   = rdata_q;
  assign RefillIdx    = idx_q;
  assign IRefillDone  = i_done_q;
  assign DRefillDone  = d_done_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Bench for mem_refill_ctrl: table of miss scenarios plus hand-written reset, drop and stray-ack sequences.
module tb_mem_refill_ctrl;

  logic        Clk, Rst;
  logic        Imiss, Dmiss, MemReq, MemAck;
  logic [31:0] IMissAddr, DMissAddr, MemAddr, MemRData, RefillData;
  logic        IRefillValid, DRefillValid, IRefillDone, DRefillDone, Busy;
  logic [1:0]  RefillIdx;

  mem_refill_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .Imiss(Imiss), .IMissAddr(IMissAddr),
    .Dmiss(Dmiss), .DMissAddr(DMissAddr),
    .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemRData(MemRData),
    .IRefillValid(IRefillValid), .DRefillValid(DRefillValid),
    .RefillData(RefillData), .RefillIdx(RefillIdx),
    .IRefillDone(IRefillDone), .DRefillDone(DRefillDone),
    .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          imiss;
    logic [31:0] iaddr;
    bit          dmiss;
    logic [31:0] daddr;
    int          delay;
    int          hold;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [1:0]  idx;
    logic [31:0] data;
  } word_t;

  logic [31:0] exp_a[$];
  word_t       exp_w[$];
  bit          exp_d[$];

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int ack_delay = 0;
  int hold = 0;
  int wait_cnt = 0;
  int words_seen = 0;
  int first_done = -1;
  int i_rel = 0;
  int d_rel = 0;
  bit in_req = 0;
  bit stray = 0;
  logic [31:0] held_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_line(input bit is_d, input logic [31:0] miss,
                             input int nreq, input int nw, input bit dn);
    logic [31:0] base;
    base = miss & ~32'h0000_000F;
    for (int j = 0; j < nreq; j++) exp_a.push_back(base + 32'(4 * j));
    for (int j = 0; j < nw; j++) begin
      word_t w;
      w.is_d = is_d;
      w.idx  = 2'(j);
      w.data = mem_word(base + 32'(4 * j));
      exp_w.push_back(w);
    end
    if (dn) exp_d.push_back(is_d);
  endtask

  // One cycle: check outputs at the falling edge, then drive the memory model and miss releases.
  task automatic step();
    @(negedge Clk);
    cyc_n++;
    if (IRefillValid || DRefillValid) begin
      chk("valid_one_port", 32'(IRefillValid && DRefillValid), 32'd0);
      chk("word_expected", 32'(exp_w.size() != 0), 32'd1);
      if (exp_w.size() != 0) begin
        word_t w;
        w = exp_w.pop_front();
        chk("valid_port", 32'(DRefillValid), 32'(w.is_d));
        chk("refill_idx", 32'(RefillIdx), 32'(w.idx));
        chk("refill_data", RefillData, w.data);
      end
      words_seen++;
    end
    if (IRefillDone || DRefillDone) begin
      chk("done_one_port", 32'(IRefillDone && DRefillDone), 32'd0);
      chk("done_expected", 32'(exp_d.size() != 0), 32'd1);
      if (exp_d.size() != 0) chk("done_port", 32'(DRefillDone), 32'(exp_d.pop_front()));
      if (first_done < 0) first_done = cyc_n;
      if (DRefillDone) d_rel = hold + 1;
      else             i_rel = hold + 1;
    end
    if (i_rel > 0) begin i_rel--; if (i_rel == 0) Imiss = 1'b0; end
    if (d_rel > 0) begin d_rel--; if (d_rel == 0) Dmiss = 1'b0; end

    MemAck = 1'b0;
    if (stray) begin
      MemAck   = 1'b1;
      MemRData = 32'hDEAD_BEEF;
      stray    = 1'b0;
    end else begin
      if (in_req) begin
        chk("req_held", 32'(MemReq), 32'd1);
        chk("addr_stable", MemAddr, held_addr);
      end else if (MemReq) begin
        chk("req_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) chk("mem_addr", MemAddr, exp_a.pop_front());
        in_req    = 1'b1;
        held_addr = MemAddr;
        wait_cnt  = 0;
      end
      if (in_req) begin
        if (wait_cnt >= ack_delay) begin
          MemAck   = 1'b1;
          MemRData = mem_word(MemAddr);
          in_req   = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  task automatic run_idle(input int budget);
    int  n;
    bit  pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      step();
      n++;
      pending = Busy || Imiss || Dmiss || (exp_a.size() != 0) ||
                (exp_w.size() != 0) || (exp_d.size() != 0);
    end
    chk("drained", 32'(pending), 32'd0);
    repeat (3) step();
    chk("idle_busy", 32'(Busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_memreq"}, 32'(MemReq), 32'd0);
    chk({tag, "_memaddr"}, MemAddr, 32'd0);
    chk({tag, "_ivalid"}, 32'(IRefillValid), 32'd0);
    chk({tag, "_dvalid"}, 32'(DRefillValid), 32'd0);
    chk({tag, "_data"}, RefillData, 32'd0);
    chk({tag, "_idx"}, 32'(RefillIdx), 32'd0);
    chk({tag, "_idone"}, 32'(IRefillDone), 32'd0);
    chk({tag, "_ddone"}, 32'(DRefillDone), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   start, n;
    vecs[0] = '{1'b1, 32'h0000_1034, 1'b0, 32'h0,         0, 0,  9};
    vecs[1] = '{1'b1, 32'h0000_1034, 1'b1, 32'h0000_2000, 0, 0,  9};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0000_ABCF, 3, 0, 21};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1, 0, 13};
    vecs[4] = '{1'b1, 32'h0000_4000, 1'b0, 32'h0,         0, 2,  9};
    vecs[5] = '{1'b0, 32'h0,         1'b1, 32'h0000_0080, 2, 0, 17};

    Rst = 1'b1; Imiss = 1'b0; Dmiss = 1'b0; IMissAddr = '0; DMissAddr = '0;
    MemAck = 1'b0; MemRData = '0;
    #3 Rst = 1'b0;
    #4 chk_zero("reset");
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    step();

    foreach (vecs[k]) begin
      ack_delay  = vecs[k].delay;
      hold       = vecs[k].hold;
      first_done = -1;
      if (vecs[k].dmiss) expect_line(1'b1, vecs[k].daddr, 4, 4, 1'b1);
      if (vecs[k].imiss) expect_line(1'b0, vecs[k].iaddr, 4, 4, 1'b1);
      DMissAddr = vecs[k].daddr;
      IMissAddr = vecs[k].iaddr;
      Dmiss     = vecs[k].dmiss;
      Imiss     = vecs[k].imiss;
      start     = cyc_n;
      run_idle(300);
      chk("done_latency", 32'(first_done - start), 32'(vecs[k].exp_lat));
    end

    // Data miss withdrawn after the first word still completes the line.
    ack_delay = 1; hold = 0; words_seen = 0;
    expect_line(1'b1, 32'h0000_5008, 4, 4, 1'b1);
    DMissAddr = 32'h0000_5008; Dmiss = 1'b1;
    n = 0;
    while (words_seen == 0 && n < 50) begin step(); n++; end
    chk("drop_first_word", 32'(words_seen), 32'd1);
    Dmiss = 1'b0;
    chk("drop_busy_mid", 32'(Busy), 32'd1);
    run_idle(200);
    chk("drop_all_words", 32'(words_seen), 32'd4);

    // Reset while the third word request is outstanding, then a stray ack.
    ack_delay = 0; words_seen = 0;
    expect_line(1'b0, 32'h0000_3004, 3, 2, 1'b0);
    IMissAddr = 32'h0000_3004; Imiss = 1'b1;
    n = 0;
    while (words_seen < 2 && n < 60) begin step(); n++; end
    chk("rst_two_words", 32'(words_seen), 32'd2);
    step();
    chk("rst_req_before", 32'(MemReq), 32'd1);
    Rst = 1'b0;
    #1 chk_zero("midrst");
    MemAck = 1'b0; Imiss = 1'b0; in_req = 1'b0;
    repeat (2) step();
    Rst = 1'b1;
    stray = 1'b1;
    repeat (4) step();
    chk("rst_after_busy", 32'(Busy), 32'd0);
    chk("rst_after_req", 32'(MemReq), 32'd0);
    chk("rst_words", 32'(words_seen), 32'd2);
    chk("rst_queues", 32'(exp_a.size() + exp_w.size() + exp_d.size()), 32'd0);

    // Stray ack while idle.
    stray = 1'b1;
    repeat (4) step();
    chk("stray_busy", 32'(Busy), 32'd0);
    chk("stray_req", 32'(MemReq), 32'd0);
    chk("stray_words", 32'(words_seen), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
